// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU-wide constants and types used by the write-back stage and the
//   GPR file.
//
//   DATA_W    GPR / datapath width
//   NREG      number of general purpose registers
//   REG_W     register index width
//   CNT_W     default retired-write counter width
//   REG_ZERO  index of the hardwired-zero register
//   reg_idx_t register index type
//   word_t    datapath word type
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int REG_W  = $clog2(NREG);
    localparam int CNT_W  = 32;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/gpr_array.sv
// ----------------------------------------------------------------------------
// gpr_array
//   NREG x DATA_W register storage. One write port, three raw (unbypassed)
//   combinational read ports, asynchronous clear of every entry.
//   Entry 0 is never written, so it always reads as zero.
//
// Ports
//   clk        in   1       clock, writes on posedge
//   rst        in   1       asynchronous active-high clear of all entries
//   i_we       in   1       write enable
//   i_waddr    in   REG_W   write register number
//   i_wdata    in   DATA_W  write data
//   i_raddr_a  in   REG_W   read port A register number
//   i_raddr_b  in   REG_W   read port B register number
//   i_raddr_c  in   REG_W   read port C register number
//   o_rdata_a  out  DATA_W  raw contents of entry i_raddr_a
//   o_rdata_b  out  DATA_W  raw contents of entry i_raddr_b
//   o_rdata_c  out  DATA_W  raw contents of entry i_raddr_c
// ----------------------------------------------------------------------------
module gpr_array #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = cpu_pkg::NREG,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_W-1:0]  i_raddr_a,
    input  logic [REG_W-1:0]  i_raddr_b,
    input  logic [REG_W-1:0]  i_raddr_c,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   w_we_onehot;

    // One-hot write decode; entry 0 never gets an enable.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            if (gi == 0) begin : g_zero
                assign w_we_onehot[gi] = 1'b0;
            end else begin : g_wr
                assign w_we_onehot[gi] = i_we && (i_waddr == REG_W'(gi));
            end
        end
    endgenerate

    // Flop-based storage: the asynchronous whole-array clear rules out RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_we_onehot[i]) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
    assign o_rdata_c = r_mem[i_raddr_c];

endmodule

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage at the end of the MEM/WB register. Selects the
//   write-back value, commits it to the GPR file, serves two ID-stage read
//   ports with write-first bypass plus an unbypassed debug port, and counts
//   committed writes.
//
// Ports
//   clk           in   1       clock, all state on posedge
//   rst           in   1       asynchronous active-high reset
//   RegWrite_in   in   1       write enable from MEM/WB
//   MemtoReg_in   in   1       1: load data, 0: ALU result
//   ADDR_in       in   DATA_W  ALU result / address
//   RD_in         in   DATA_W  load data
//   WN_in         in   REG_W   destination register number
//   RN1           in   REG_W   read port 1 register number
//   RN2           in   REG_W   read port 2 register number
//   DBG_RN        in   REG_W   debug read register number
//   RD1           out  DATA_W  read data port 1 (bypassed)
//   RD2           out  DATA_W  read data port 2 (bypassed)
//   DBG_RD        out  DATA_W  debug read data (array contents only)
//   WD_out        out  DATA_W  selected write-back value
//   wb_valid_out  out  1       a register write commits this cycle
//   retire_cnt    out  CNT_W   wrapping count of committed writes
// ----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREG   = cpu_pkg::NREG,
    parameter int CNT_W  = cpu_pkg::CNT_W,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] ADDR_in,
    input  logic [DATA_W-1:0] RD_in,
    input  logic [REG_W-1:0]  WN_in,
    input  logic [REG_W-1:0]  RN1,
    input  logic [REG_W-1:0]  RN2,
    input  logic [REG_W-1:0]  DBG_RN,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] DBG_RD,
    output logic [DATA_W-1:0] WD_out,
    output logic              wb_valid_out,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [DATA_W-1:0]          w_wd;
    logic                       w_commit;
    logic [1:0][REG_W-1:0]      w_rn;
    logic [1:0][DATA_W-1:0]     w_raw;
    logic [1:0][DATA_W-1:0]     w_rd;
    logic [CNT_W-1:0]           r_retire_cnt;

    // Write-back mux.
    assign w_wd = MemtoReg_in ? RD_in : ADDR_in;

    // A write to r0 is a no-op. Reset suppresses the commit so nothing
    // leaks through the bypass while the array is held clear.
    assign w_commit = RegWrite_in && (WN_in != '0) && !rst;

    gpr_array #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_gpr_array (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_commit),
        .i_waddr    (WN_in),
        .i_wdata    (w_wd),
        .i_raddr_a  (RN1),
        .i_raddr_b  (RN2),
        .i_raddr_c  (DBG_RN),
        .o_rdata_a  (w_raw[0]),
        .o_rdata_b  (w_raw[1]),
        .o_rdata_c  (DBG_RD)
    );

    assign w_rn[0] = RN1;
    assign w_rn[1] = RN2;

    // Per-port read path: zero register, then write-first bypass, then array.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                w_rd[gi] = w_raw[gi];
                if (rst || (w_rn[gi] == '0)) begin
                    w_rd[gi] = '0;
                end else if (w_commit && (WN_in == w_rn[gi])) begin
                    w_rd[gi] = w_wd;
                end
            end
        end
    endgenerate

    // Committed-write counter, wraps with no saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_commit) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign RD1          = w_rd[0];
    assign RD2          = w_rd[1];
    assign WD_out       = w_wd;
    assign wb_valid_out = w_commit;
    assign retire_cnt   = r_retire_cnt;

`ifndef SYNTHESIS
    // An unknown write enable outside reset means the MEM/WB register is broken.
    a_regwrite_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(RegWrite_in));
`endif

endmodule
